// File: rtl/prog_mem_loader.sv
// prog_mem_loader: byte-wide program/data memory for the 6502 core.
// A loader port fills the array byte-serially while the CPU is held in
// reset; afterwards the CPU gets registered reads (with optional wait
// states) and single-cycle writes inside a BASE_ADDR-relative window.
// Memory contents deliberately survive reset so a partially loaded image
// is kept when the loader is interrupted.

module prog_mem_loader #(
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       DEPTH       = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h0000,
    parameter int unsigned       WAIT_STATES = 0,
    parameter logic [7:0]        FILL_BYTE   = 8'hEA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic [ADDR_W-1:0] load_count,
    output logic              load_overflow,
    output logic              cpu_hold,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_din,
    output logic              cpu_rdy
);

    localparam int unsigned      IDX_W     = $clog2(DEPTH);
    // One extra bit so the counter can hold DEPTH even when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]       WAIT_INIT = 4'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // True when the CPU address falls inside the mapped window.
    function automatic logic in_window(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ({1'b0, off} < DEPTH_EXT);
    endfunction

    // Array index of a CPU address (only meaningful when in_window is true).
    function automatic logic [IDX_W-1:0] window_index(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return off[IDX_W-1:0];
    endfunction

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [ADDR_W:0]   cnt_r;
    logic              ovf_r;
    logic              load_ready_r;
    logic              cpu_hold_r;
    logic              rdy_r;
    logic [7:0]        din_r;
    logic [ADDR_W-1:0] addr_q_r;
    logic [3:0]        wait_cnt_r;
    logic [3:0]        wait_nxt_s;
    logic              xfer_s;
    logic              load_start_s;
    logic              load_wr_s;
    logic              cpu_wr_s;
    logic              cpu_in_range_s;
    logic              hold_nxt_s;
    logic [IDX_W-1:0]  cpu_idx_s;
    logic [IDX_W-1:0]  load_idx_s;
    logic [7:0]        mem_r [DEPTH];

    // Decode of load handshake, address window and write enables.
    always_comb begin
        xfer_s         = 1'b0;
        load_start_s   = 1'b0;
        load_wr_s      = 1'b0;
        cpu_wr_s       = 1'b0;
        cpu_in_range_s = in_window(cpu_addr);
        cpu_idx_s      = window_index(cpu_addr);
        load_idx_s     = cnt_r[IDX_W-1:0];
        if (state_r == ST_LOAD) begin
            xfer_s = load_valid && load_ready_r;
        end else begin
            xfer_s = 1'b0;
        end
        if (((state_r == ST_IDLE) || (state_r == ST_RUN)) && load_en) begin
            load_start_s = 1'b1;
        end else begin
            load_start_s = 1'b0;
        end
        if (xfer_s && (cnt_r < DEPTH_EXT)) begin
            load_wr_s = 1'b1;
        end else begin
            load_wr_s = 1'b0;
        end
        if ((state_r == ST_RUN) && cpu_we && cpu_in_range_s) begin
            cpu_wr_s = 1'b1;
        end else begin
            cpu_wr_s = 1'b0;
        end
    end

    // Next-state logic for the IDLE/LOAD/RUN controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_en) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LOAD: begin
                // A final byte ends the load even when it was discarded.
                if (xfer_s && load_last) begin
                    state_nxt_s = ST_RUN;
                end else if (!load_en) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (load_en) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        hold_nxt_s = (state_nxt_s != ST_RUN);
    end

    // Wait-state counter reload/decrement; any address change restarts it.
    always_comb begin
        wait_nxt_s = wait_cnt_r;
        if (cpu_addr != addr_q_r) begin
            wait_nxt_s = WAIT_INIT;
        end else if (wait_cnt_r != 4'd0) begin
            wait_nxt_s = wait_cnt_r - 4'd1;
        end else begin
            wait_nxt_s = 4'd0;
        end
    end

    // Controller state and the registered handshake outputs derived from it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            load_ready_r <= 1'b0;
            cpu_hold_r   <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            load_ready_r <= (state_nxt_s == ST_LOAD);
            cpu_hold_r   <= hold_nxt_s;
        end
    end

    // Load byte counter with saturation at DEPTH and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else if (load_start_s) begin
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else if (xfer_s) begin
            if (cnt_r < DEPTH_EXT) begin
                cnt_r <= cnt_r + 1'b1;
            end else begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Storage array write port; loader and CPU writes are exclusive by state.
    always_ff @(posedge clk) begin
        if (load_wr_s) begin
            mem_r[load_idx_s] <= load_data;
        end else if (cpu_wr_s) begin
            mem_r[cpu_idx_s] <= cpu_wdata;
        end
    end

    // Registered read port; same-edge writes are seen one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din_r <= FILL_BYTE;
        end else if (cpu_in_range_s) begin
            din_r <= mem_r[cpu_idx_s];
        end else begin
            din_r <= FILL_BYTE;
        end
    end

    // Address tracking, wait counter and ready flag aligned with cpu_din.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q_r   <= '0;
            wait_cnt_r <= 4'd0;
            rdy_r      <= 1'b0;
        end else begin
            addr_q_r   <= cpu_addr;
            wait_cnt_r <= wait_nxt_s;
            rdy_r      <= (wait_nxt_s == 4'd0) && !hold_nxt_s;
        end
    end

    assign load_ready    = load_ready_r;
    assign load_count    = cnt_r[ADDR_W-1:0];
    assign load_overflow = ovf_r;
    assign cpu_hold      = cpu_hold_r;
    assign cpu_din       = din_r;
    assign cpu_rdy       = rdy_r;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: instance A uses the default map
// (256 bytes at 0, no wait states); instance B is a 16-byte window at
// 16'h0200 with 3 wait states for overflow, wait and mapping cases.

module tb_prog_mem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Instance A signals
    logic        a_reset, a_load_en, a_load_valid, a_load_last, a_cpu_we;
    logic [7:0]  a_load_data, a_cpu_wdata, a_cpu_din;
    logic [15:0] a_load_count, a_cpu_addr;
    logic        a_load_ready, a_load_overflow, a_cpu_hold, a_cpu_rdy;

    // Instance B signals
    logic        b_reset, b_load_en, b_load_valid, b_load_last, b_cpu_we;
    logic [7:0]  b_load_data, b_cpu_wdata, b_cpu_din;
    logic [15:0] b_load_count, b_cpu_addr;
    logic        b_load_ready, b_load_overflow, b_cpu_hold, b_cpu_rdy;

    logic [7:0]  img [28];

    prog_mem_loader dut_a (
        .clk(clk), .reset(a_reset), .load_en(a_load_en), .load_valid(a_load_valid),
        .load_data(a_load_data), .load_last(a_load_last), .load_ready(a_load_ready),
        .load_count(a_load_count), .load_overflow(a_load_overflow), .cpu_hold(a_cpu_hold),
        .cpu_addr(a_cpu_addr), .cpu_we(a_cpu_we), .cpu_wdata(a_cpu_wdata),
        .cpu_din(a_cpu_din), .cpu_rdy(a_cpu_rdy)
    );

    prog_mem_loader #(
        .ADDR_W(16), .DEPTH(16), .BASE_ADDR(16'h0200), .WAIT_STATES(3), .FILL_BYTE(8'hEA)
    ) dut_b (
        .clk(clk), .reset(b_reset), .load_en(b_load_en), .load_valid(b_load_valid),
        .load_data(b_load_data), .load_last(b_load_last), .load_ready(b_load_ready),
        .load_count(b_load_count), .load_overflow(b_load_overflow), .cpu_hold(b_cpu_hold),
        .cpu_addr(b_cpu_addr), .cpu_we(b_cpu_we), .cpu_wdata(b_cpu_wdata),
        .cpu_din(b_cpu_din), .cpu_rdy(b_cpu_rdy)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic a_push(input logic [7:0] d, input logic last);
        a_load_valid = 1'b1;
        a_load_data  = d;
        a_load_last  = last;
        @(negedge clk);
        a_load_valid = 1'b0;
        a_load_last  = 1'b0;
    endtask

    task automatic b_push(input logic [7:0] d, input logic last);
        b_load_valid = 1'b1;
        b_load_data  = d;
        b_load_last  = last;
        @(negedge clk);
        b_load_valid = 1'b0;
        b_load_last  = 1'b0;
    endtask

    initial begin
        a_reset = 1'b0; a_load_en = 1'b1; a_load_valid = 1'b0; a_load_last = 1'b0;
        a_load_data = 8'h00; a_cpu_we = 1'b0; a_cpu_wdata = 8'h00; a_cpu_addr = 16'h0000;
        b_reset = 1'b0; b_load_en = 1'b1; b_load_valid = 1'b0; b_load_last = 1'b0;
        b_load_data = 8'h00; b_cpu_we = 1'b0; b_cpu_wdata = 8'h00; b_cpu_addr = 16'h0000;
        for (int i = 0; i < 28; i++) img[i] = 8'(i + 16);
        img[0] = 8'hA9; img[1] = 8'h03; img[2] = 8'h38; img[26] = 8'hB5; img[27] = 8'h01;

        // ---- Reset state ----
        step(2);
        check("rst_hold",  16'(a_cpu_hold), 16'h1);
        check("rst_ready", 16'(a_load_ready), 16'h0);
        check("rst_count", a_load_count, 16'h0);
        check("rst_ovf",   16'(a_load_overflow), 16'h0);
        check("rst_din",   16'(a_cpu_din), 16'h00EA);
        check("rst_rdy",   16'(a_cpu_rdy), 16'h0);

        // ---- Test 1: 28-byte image ----
        a_reset = 1'b1;
        step(1);
        check("t1_ready", 16'(a_load_ready), 16'h1);
        check("t1_hold_load", 16'(a_cpu_hold), 16'h1);
        a_push(img[0], 1'b0);
        check("t1_count1", a_load_count, 16'd1);
        for (int i = 1; i < 28; i++) begin
            a_push(img[i], (i == 27));
            if (i == 26) check("t1_hold_before_last", 16'(a_cpu_hold), 16'h1);
        end
        a_load_en = 1'b0;
        check("t1_count28", a_load_count, 16'd28);
        check("t1_hold_fall", 16'(a_cpu_hold), 16'h0);
        check("t1_ready_low", 16'(a_load_ready), 16'h0);
        a_cpu_addr = 16'd27;
        step(1);
        check("t1_din27", 16'(a_cpu_din), 16'h0001);
        check("t1_rdy27", 16'(a_cpu_rdy), 16'h1);
        a_cpu_addr = 16'd0;
        step(1);
        check("t1_din0", 16'(a_cpu_din), 16'h00A9);
        check("t1_rdy0", 16'(a_cpu_rdy), 16'h1);
        a_cpu_addr = 16'd2;
        step(1);
        check("t1_din2", 16'(a_cpu_din), 16'h0038);
        a_cpu_addr = 16'd26;
        step(1);
        check("t1_din26", 16'(a_cpu_din), 16'h00B5);

        // ---- Test 6: load_en together with a CPU write ----
        a_cpu_addr = 16'd0;
        step(1);
        a_load_en = 1'b1; a_cpu_we = 1'b1; a_cpu_wdata = 8'h77;
        step(1);
        a_cpu_we = 1'b0;
        check("t6_hold", 16'(a_cpu_hold), 16'h1);
        check("t6_count", a_load_count, 16'h0);
        check("t6_ready", 16'(a_load_ready), 16'h1);
        check("t6_din_old", 16'(a_cpu_din), 16'h00A9);
        step(1);
        check("t6_din_new", 16'(a_cpu_din), 16'h0077);
        check("t6_rdy_held", 16'(a_cpu_rdy), 16'h0);

        // ---- Test 5: reset mid-load, then partial reload ----
        a_push(8'h11, 1'b0); a_push(8'h22, 1'b0); a_push(8'h33, 1'b0);
        a_push(8'h44, 1'b0); a_push(8'h55, 1'b0);
        check("t5_count5", a_load_count, 16'd5);
        #2 a_reset = 1'b0;
        #1;
        check("t5_rst_hold", 16'(a_cpu_hold), 16'h1);
        check("t5_rst_count", a_load_count, 16'h0);
        check("t5_rst_ready", 16'(a_load_ready), 16'h0);
        @(negedge clk);
        a_reset = 1'b1;
        step(1);
        check("t5_reload_ready", 16'(a_load_ready), 16'h1);
        a_push(8'h66, 1'b0); a_push(8'h67, 1'b0); a_push(8'h68, 1'b1);
        a_load_en = 1'b0;
        check("t5_count3", a_load_count, 16'd3);
        check("t5_hold", 16'(a_cpu_hold), 16'h0);
        a_cpu_addr = 16'd0; step(1); check("t5_mem0", 16'(a_cpu_din), 16'h0066);
        a_cpu_addr = 16'd2; step(1); check("t5_mem2", 16'(a_cpu_din), 16'h0068);
        a_cpu_addr = 16'd3; step(1); check("t5_mem3", 16'(a_cpu_din), 16'h0044);
        a_cpu_addr = 16'd4; step(1); check("t5_mem4", 16'(a_cpu_din), 16'h0055);

        // ---- Test 2: overflow with DEPTH=16 ----
        b_reset = 1'b1;
        step(1);
        check("t2_ready", 16'(b_load_ready), 16'h1);
        for (int i = 0; i < 18; i++) begin
            b_push(8'(8'hC0 + i), (i == 17));
            if (i == 15) check("t2_ovf_clear16", 16'(b_load_overflow), 16'h0);
        end
        b_load_en = 1'b0;
        check("t2_count", b_load_count, 16'd16);
        check("t2_ovf", 16'(b_load_overflow), 16'h1);
        check("t2_hold", 16'(b_cpu_hold), 16'h0);
        b_cpu_addr = 16'h020F;
        step(4);
        check("t2_mem15", 16'(b_cpu_din), 16'h00CF);
        check("t2_rdy15", 16'(b_cpu_rdy), 16'h1);
        b_cpu_addr = 16'h0210;
        step(4);
        check("t2_beyond", 16'(b_cpu_din), 16'h00EA);

        // ---- Test 3: wait states ----
        b_cpu_addr = 16'h0200;
        step(4);
        check("t3_base_din", 16'(b_cpu_din), 16'h00C0);
        b_cpu_addr = 16'h0201;
        step(1); check("t3_w1", 16'(b_cpu_rdy), 16'h0);
        step(1); check("t3_w2", 16'(b_cpu_rdy), 16'h0);
        step(1); check("t3_w3", 16'(b_cpu_rdy), 16'h0);
        step(1); check("t3_rdy4", 16'(b_cpu_rdy), 16'h1);
        check("t3_din1", 16'(b_cpu_din), 16'h00C1);
        b_cpu_addr = 16'h0202;
        step(2);
        b_cpu_addr = 16'h0203;
        step(1); check("t3_r1", 16'(b_cpu_rdy), 16'h0);
        step(1); check("t3_r2", 16'(b_cpu_rdy), 16'h0);
        step(1); check("t3_r3", 16'(b_cpu_rdy), 16'h0);
        step(1); check("t3_rdy_restart", 16'(b_cpu_rdy), 16'h1);
        check("t3_din3", 16'(b_cpu_din), 16'h00C3);

        // ---- Test 4: base address mapping and CPU writes ----
        b_cpu_addr = 16'h0100;
        step(1);
        check("t4_unmapped", 16'(b_cpu_din), 16'h00EA);
        b_cpu_we = 1'b1; b_cpu_wdata = 8'h55;
        step(1);
        b_cpu_we = 1'b0;
        b_cpu_addr = 16'h0200;
        step(4);
        check("t4_no_alias", 16'(b_cpu_din), 16'h00C0);
        b_cpu_addr = 16'h0205; b_cpu_we = 1'b1; b_cpu_wdata = 8'h55;
        step(1);
        b_cpu_we = 1'b0;
        check("t4_read_first", 16'(b_cpu_din), 16'h00C5);
        step(1);
        check("t4_written", 16'(b_cpu_din), 16'h0055);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
Parametrised program/data memory for the 6502 core, replacing the fixed behavioural ROM array with synthesizable storage.
- Loader port: fills memory byte-serially while the CPU is held in reset.
- CPU port: registered reads with configurable wait states, and single-cycle writes.
- Placement: sits between cpu_core's addr/din bus and the board-level loader (UART or test bench).

Parameters:
ADDR_W, 16, CPU address width
DEPTH, 256, bytes of storage (power of two, <= 2**ADDR_W)
BASE_ADDR, 16'h0000, first CPU address mapped to mem[0]
WAIT_STATES, 0, extra cycles cpu_rdy stays low after an address change (0..15)
FILL_BYTE, 8'hEA, value returned for unmapped reads (NOP)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
load_en  in  1  request load mode
load_valid  in  1  load_data valid
load_data  in  8  byte to store
load_last  in  1  marks final byte of image (qualified by load_valid)
load_ready  out  1  loader may transfer
load_count  out  ADDR_W  bytes accepted in current load
load_overflow  out  1  sticky: byte arrived with pointer >= DEPTH
cpu_hold  out  1  hold cpu_core in reset
cpu_addr  in  ADDR_W  CPU address
cpu_we  in  1  CPU write strobe
cpu_wdata  in  8  CPU write data
cpu_din  out  8  read data to CPU
cpu_rdy  out  1  cpu_din valid for current cpu_addr

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cpu_hold=1, load_ready=0, load_count=0, load_overflow=0.
  - cpu_din=FILL_BYTE, cpu_rdy=0, wait_cnt=0, addr_q=0.
  - Memory contents are not reset.
- FSM states: IDLE, LOAD, RUN.
- IDLE:
  - load_en=1 -> LOAD; clears load_count and load_overflow.
  - else -> RUN.
- LOAD:
  - load_ready=1, cpu_hold=1.
  - Transfer = load_valid && load_ready.
  - Each transfer with load_count < DEPTH writes mem[load_count] and increments load_count.
  - Transfer with load_count >= DEPTH: byte discarded, load_overflow set; count saturates at DEPTH.
  - Transfer with load_last=1 -> RUN on the next edge; load_ready=0 from that cycle.
  - load_en deasserting mid-load -> RUN after the current cycle; bytes already written are kept.
- RUN:
  - cpu_hold=0, load_ready=0.
  - load_en=1 -> LOAD; cpu_hold=1 from the next cycle, and load_count/load_overflow clear.
- Mapping: address a is in range iff BASE_ADDR <= a < BASE_ADDR+DEPTH. Index = a-BASE_ADDR, truncated to log2(DEPTH) bits.
- Read path, every cycle:
  - cpu_din <= in range ? mem[index] : FILL_BYTE. Latency is 1 cycle.
  - Read-first: a same-cycle write to the same index returns the old byte; the new byte appears the following cycle.
- Ready logic:
  - addr_q <= cpu_addr every cycle.
  - If cpu_addr != addr_q: wait_cnt <= WAIT_STATES; else if wait_cnt != 0, wait_cnt decrements.
  - cpu_rdy = (cpu_addr == addr_q) && (wait_cnt == 0) && !cpu_hold, registered consistently so it asserts the cycle cpu_din is valid.
  - WAIT_STATES=0: rdy is high 1 cycle after a new address.
  - WAIT_STATES=N: rdy is high N+1 cycles after a new address.
  - Address change during a wait restarts the count.
- CPU writes:
  - Accepted only in RUN, with cpu_we=1 and address in range; the write happens on the edge.
  - Out-of-range writes and writes during LOAD/IDLE are ignored.
  - Writes do not touch wait_cnt.
- Simultaneous events:
  - load_en rising in the same cycle as cpu_we in RUN: the CPU write completes, then LOAD.
  - load_last on a discarded (overflow) byte still ends the load.
- Reset mid-LOAD: returns to IDLE immediately. Partial image remains in memory; load_count clears.

Test Plan:
1. Reset, load_en=1, stream 28 bytes A9,03,38,…,B5,01 with load_last on byte 28 -> load_count=28, state RUN, cpu_hold falls the cycle after the last transfer. cpu_addr=0 gives cpu_din=A9 with rdy after 1 cycle; addr 27 gives 01.
2. DEPTH=16, stream 18 bytes -> load_count=16, load_overflow=1, mem[15] = byte 16, bytes 17/18 absent.
3. WAIT_STATES=3: step cpu_addr 0→1 -> cpu_rdy low 3 cycles, high on the 4th with cpu_din=mem[1]. Change the address on wait cycle 2 -> count restarts.
4. BASE_ADDR=16'h0200: read 16'h0100 -> cpu_din=EA. Write 55 to 16'h0100 -> ignored. Write 55 to 16'h0205 -> reading 16'h0205 gives 55; a same-cycle read shows the old value.
5. Assert reset low mid-load after 5 bytes -> cpu_hold=1, load_count=0, state IDLE. Reload 3 bytes -> mem[0..2] new, mem[3..4] retain the earlier bytes.
6. In RUN, raise load_en together with cpu_we to addr 0 (data 77) -> write lands, cpu_hold=1 next cycle, load_count=0.
